gray_conv_arbiter: RTL

//  Shares one registered Gray-code conversion stage between N_REQ requesters.

---
 rtl/gray_conv_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin arbiter that shares one registered
// binary<->Gray conversion stage between N_REQ requesters and returns each
// result on a single valid/ready response port, tagged with requester ID.
module gray_conv_arbiter #(
  parameter int unsigned  W     = 4,
  parameter int unsigned  N_REQ = 4,
  localparam int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_mode,
  input  logic [N_REQ*W-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [W-1:0]         resp_data,
  output logic [IDW-1:0]       resp_id,
  output logic                 resp_mode,
  output logic [15:0]          done_cnt
);

  localparam logic [15:0] DONE_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id_reg;
  logic [W-1:0]   op_reg;
  logic           mode_reg;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [W-1:0]   grant_data;
  logic           grant_mode;
  logic [IDW-1:0] rr_next;
  logic           accept;
  logic [W-1:0]   conv_result;

  // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
  function automatic logic [W-1:0] bin_to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each bit is the XOR of all Gray bits at or above it.
  function automatic logic [W-1:0] gray_to_bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int unsigned s = 1; s < W; s++) begin
      b = b ^ (g >> s);
    end
    return b;
  endfunction

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    int unsigned      idx;
    logic [N_REQ-1:0] shifted;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    shifted     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx     = (32'(rr_ptr) + k) % N_REQ;
      shifted = req_valid >> idx;
      if (!grant_found && shifted[0]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  // Operand, mode and next pointer of the granted requester.
  always_comb begin
    logic [N_REQ-1:0] mode_sh;
    mode_sh    = req_mode >> grant_idx;
    grant_mode = mode_sh[0];
    grant_data = W'(req_data >> (32'(grant_idx) * W));
    rr_next    = IDW'((32'(grant_idx) + 1) % N_REQ);
  end

  // One-hot accept, only offered while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && grant_found) begin
      req_ready = N_REQ'(1) << grant_idx;
    end
  end

  assign accept = |(req_valid & req_ready);

  // Shared conversion stage fed from the latched operand.
  always_comb begin
    conv_result = mode_reg ? gray_to_bin(op_reg) : bin_to_gray(op_reg);
  end

  // Control FSM with registered response and completion counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      id_reg     <= '0;
      op_reg     <= '0;
      mode_reg   <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      resp_mode  <= 1'b0;
      done_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_reg   <= grant_data;
            mode_reg <= grant_mode;
            id_reg   <= grant_idx;
            rr_ptr   <= rr_next;
            state    <= CONV;
          end
        end
        CONV: begin
          resp_data  <= conv_result;
          resp_id    <= id_reg;
          resp_mode  <= mode_reg;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
            if (done_cnt != DONE_MAX) begin
              done_cnt <= done_cnt + 16'd1;
            end
          end
        end
        default: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
